gbe_multi_packetizer: RTL and testbench

Multi-channel successor to the single-stream GbE write packetizer. NUM_CH independent input streams are each buffered in a per-channel FIFO. A round-robin arbiter sends one whole packet at a time from any channel holding at least one full packet. Each packet is serialised to DOUT_WIDTH beats, optionally prefixed by a header beat (channel id + per-channel sequence number), and sent to the 10GbE core with a per-channel destination port and a programmable inter-packet gap.

---
 rtl/gbe_pkt_pkg.sv | 24 ++
 rtl/gbe_pkt_fifo.sv | 61 ++++++
 rtl/gbe_multi_packetizer.sv | 258 +++++++++++++++++++++++++
 tb/tb_gbe_multi_packetizer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbe_pkt_pkg.sv
// Shared types and constants for the multi-channel GbE packetizer.
// Holds FSM encodings, header field layout and the slice-count helper.
package gbe_pkt_pkg;

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_ARB  = 2'd1,
        ST_HDR  = 2'd2,
        ST_SEND = 2'd3
    } pkt_state_t;

    localparam int CH_ID_W     = 8;
    localparam int SEQ_W       = 24;
    localparam int HDR_SEQ_LSB = 0;
    localparam int HDR_CH_LSB  = SEQ_W;

    function automatic int slice_count(
        input int din_w,
        input int dout_w
    );
        return din_w / dout_w;
    endfunction

endpackage

// File: rtl/gbe_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO with fill count.
// Ports: clk, rst (sync, high), i_wr_en/i_wr_data, i_rd_en/o_rd_data,
//        o_full, o_count (words held). Writes when full are ignored.
module gbe_pkt_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [W-1:0]               i_wr_data,
    input  logic                       i_rd_en,
    output logic [W-1:0]               o_rd_data,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && (r_count != '0);

    // Storage kept out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gbe_multi_packetizer.sv
// NUM_CH-channel packetizer: per-channel FIFOs, round-robin packet
// arbitration, optional header beat, serialisation to DOUT_WIDTH beats.
// Ports: din/din_valid per channel; pkt_len, sleep_cycles, header_en,
//        config_tx_dest_ip/port config; tx_afull from the core;
//        tx_* beat stream; fifo_full, overflow, pkt_count status.
module gbe_multi_packetizer
    import gbe_pkt_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DIN_WIDTH  = 128,
    parameter int DOUT_WIDTH = 64,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*DIN_WIDTH-1:0] din,
    input  logic [NUM_CH-1:0]           din_valid,
    input  logic [15:0]                 pkt_len,
    input  logic [31:0]                 sleep_cycles,
    input  logic                        header_en,
    input  logic [31:0]                 config_tx_dest_ip,
    input  logic [15:0]                 config_tx_dest_port,
    input  logic                        tx_afull,
    output logic [DOUT_WIDTH-1:0]       tx_data,
    output logic                        tx_valid,
    output logic                        tx_eof,
    output logic [31:0]                 tx_dest_ip,
    output logic [15:0]                 tx_dest_port,
    output logic [NUM_CH-1:0]           fifo_full,
    output logic [NUM_CH-1:0]           overflow,
    output logic [31:0]                 pkt_count
);

    localparam int R   = slice_count(DIN_WIDTH, DOUT_WIDTH);
    localparam int SW  = (R > 1) ? $clog2(R) : 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    pkt_state_t            r_state;
    pkt_state_t            w_state_nxt;
    logic [31:0]           r_gap;
    logic [CHW-1:0]        r_ch;
    logic [CHW-1:0]        r_last;
    logic [SW-1:0]         r_slice;
    logic [15:0]           r_wleft;
    logic [SEQ_W-1:0]      r_seq [NUM_CH];
    logic [31:0]           r_pkt_count;
    logic [NUM_CH-1:0]     r_ovf;
    logic [DOUT_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_tx_eof;
    logic [31:0]           r_dest_ip;
    logic [15:0]           r_dest_port;

    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_elig;
    logic [NUM_CH-1:0]     w_rd;
    logic [CW-1:0]         w_cnt [NUM_CH];
    logic [DIN_WIDTH-1:0]  w_dout [NUM_CH];
    logic [DIN_WIDTH-1:0]  w_head;
    logic [DOUT_WIDTH-1:0] w_hdr;
    logic [DOUT_WIDTH-1:0] w_slice;
    logic [CHW-1:0]        w_sel;
    logic                  w_any;
    logic                  w_len_ok;
    logic                  w_gap_done;
    logic                  w_start;
    logic                  w_load;
    logic                  w_done;
    logic [CHW-1:0]        w_ld_ch;
    logic [SW-1:0]         w_ld_slice;
    logic [15:0]           w_ld_wleft;
    logic                  w_ld_lastsl;
    logic                  w_ld_eof;

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign tx_eof       = r_tx_eof;
    assign tx_dest_ip   = r_dest_ip;
    assign tx_dest_port = r_dest_port;
    assign fifo_full    = w_full;
    assign overflow     = r_ovf;
    assign pkt_count    = r_pkt_count;

    assign w_len_ok = (pkt_len != 16'd0) &&
                      (32'(pkt_len) <= 32'(FIFO_DEPTH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gbe_pkt_fifo #(
            .W     (DIN_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (din_valid[c]),
            .i_wr_data (din[c*DIN_WIDTH +: DIN_WIDTH]),
            .i_rd_en   (w_rd[c]),
            .o_rd_data (w_dout[c]),
            .o_full    (w_full[c]),
            .o_count   (w_cnt[c])
        );

        assign w_elig[c] = w_len_ok &&
                           (32'(w_cnt[c]) >= 32'(pkt_len));
        assign w_rd[c]   = w_load && w_ld_lastsl &&
                           (w_ld_ch == CHW'(c));
    end

    // Round-robin: first eligible channel after the last one served.
    always_comb begin
        int idx;
        idx   = 0;
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(r_last) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!w_any && w_elig[idx]) begin
                w_any = 1'b1;
                w_sel = CHW'(idx);
            end
        end
    end

    // In ARB the beat source is the channel being granted this cycle,
    // so the first payload slice can be registered without a bubble.
    assign w_ld_ch     = (r_state == ST_ARB) ? w_sel   : r_ch;
    assign w_ld_slice  = (r_state == ST_ARB) ? '0      : r_slice;
    assign w_ld_wleft  = (r_state == ST_ARB) ? pkt_len : r_wleft;
    assign w_ld_lastsl = (w_ld_slice == SW'(R - 1));
    assign w_ld_eof    = w_ld_lastsl && (w_ld_wleft == 16'd1);
    assign w_head      = w_dout[w_ld_ch];

    // MSB slice of each word goes out first.
    always_comb begin
        w_slice = w_head[(R - 1 - int'(w_ld_slice)) * DOUT_WIDTH
                         +: DOUT_WIDTH];
    end

    always_comb begin
        w_hdr = '0;
        w_hdr[HDR_CH_LSB +: CH_ID_W] = CH_ID_W'(w_sel);
        w_hdr[HDR_SEQ_LSB +: SEQ_W]  = r_seq[w_sel];
    end

    assign w_gap_done = (sleep_cycles == 32'd0) ||
                        (r_gap >= sleep_cycles - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GAP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!tx_afull && w_any) begin
                    w_start = 1'b1;
                    if (header_en) begin
                        w_state_nxt = ST_HDR;
                    end else begin
                        w_state_nxt = ST_SEND;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                w_load      = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // Output register already holds the final beat.
                if (r_tx_eof) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap       <= '0;
            r_ch        <= '0;
            r_last      <= '0;
            r_slice     <= '0;
            r_wleft     <= '0;
            r_pkt_count <= '0;
            r_ovf       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_eof    <= 1'b0;
            r_dest_ip   <= '0;
            r_dest_port <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_seq[c] <= '0;
            end
        end else begin
            r_ovf <= r_ovf | (din_valid & w_full);

            if (r_state == ST_GAP && !w_gap_done) begin
                r_gap <= r_gap + 32'd1;
            end else begin
                r_gap <= '0;
            end

            if (w_start) begin
                r_ch        <= w_sel;
                r_slice     <= '0;
                r_wleft     <= pkt_len;
                r_dest_ip   <= config_tx_dest_ip;
                r_dest_port <= config_tx_dest_port + 16'(w_sel);
                if (header_en) begin
                    r_tx_data  <= w_hdr;
                    r_tx_valid <= 1'b1;
                    r_tx_eof   <= 1'b0;
                end
            end

            if (w_load) begin
                r_tx_data  <= w_slice;
                r_tx_valid <= 1'b1;
                r_tx_eof   <= w_ld_eof;
                r_slice    <= w_ld_lastsl ? '0 : w_ld_slice + SW'(1);
                r_wleft    <= w_ld_wleft - 16'(w_ld_lastsl);
            end

            if (w_done) begin
                r_tx_valid  <= 1'b0;
                r_tx_eof    <= 1'b0;
                r_tx_data   <= '0;
                r_seq[r_ch] <= r_seq[r_ch] + SEQ_W'(1);
                r_pkt_count <= r_pkt_count + 32'd1;
                r_last      <= r_ch;
            end
        end
    end

endmodule

// File: tb/tb_gbe_multi_packetizer.sv
// Scoreboard bench for gbe_multi_packetizer.
// Packet-level model fills an expected-beat queue; a monitor checks beats.
module tb_gbe_multi_packetizer;

    localparam int NCH   = 4;
    localparam int DIN   = 128;
    localparam int DOUT  = 64;
    localparam int DEPTH = 512;
    localparam int R     = DIN / DOUT;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH*DIN-1:0]   din;
    logic [NCH-1:0]       din_valid;
    logic [15:0]          pkt_len;
    logic [31:0]          sleep_cycles;
    logic                 header_en;
    logic [31:0]          config_tx_dest_ip;
    logic [15:0]          config_tx_dest_port;
    logic                 tx_afull;
    logic [DOUT-1:0]      tx_data;
    logic                 tx_valid;
    logic                 tx_eof;
    logic [31:0]          tx_dest_ip;
    logic [15:0]          tx_dest_port;
    logic [NCH-1:0]       fifo_full;
    logic [NCH-1:0]       overflow;
    logic [31:0]          pkt_count;

    always #5 clk = ~clk;

    gbe_multi_packetizer #(
        .NUM_CH     (NCH),
        .DIN_WIDTH  (DIN),
        .DOUT_WIDTH (DOUT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .din                 (din),
        .din_valid           (din_valid),
        .pkt_len             (pkt_len),
        .sleep_cycles        (sleep_cycles),
        .header_en           (header_en),
        .config_tx_dest_ip   (config_tx_dest_ip),
        .config_tx_dest_port (config_tx_dest_port),
        .tx_afull            (tx_afull),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_eof              (tx_eof),
        .tx_dest_ip          (tx_dest_ip),
        .tx_dest_port        (tx_dest_port),
        .fifo_full           (fifo_full),
        .overflow            (overflow),
        .pkt_count           (pkt_count)
    );

    typedef struct packed {
        logic [DOUT-1:0] d;
        logic            eof;
        logic [15:0]     port;
        logic [31:0]     ip;
    } beat_t;

    beat_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int beats_seen = 0;
    bit mon_off = 1'b0;
    int idle = 0;
    bit in_pkt = 1'b0;
    bit have_prev = 1'b0;

    logic [DIN-1:0] mmem [NCH][1024];
    int             mhead [NCH];
    int             mtail [NCH];
    logic [23:0]    mseq [NCH];
    int             mlast;
    int             mcount;
    logic [NCH-1:0] movf;

    always @(negedge clk) begin
        beat_t e;
        if (mon_off || rst) begin
            in_pkt    = 1'b0;
            have_prev = 1'b0;
            idle      = 0;
        end else if (tx_valid) begin
            beats_seen++;
            if (!in_pkt && have_prev) begin
                n_tests++;
                if (idle < int'(sleep_cycles) + 1) begin
                    n_fail++;
                    $display("FAIL gap: got %0d idle cycles, required >= %0d",
                             idle, int'(sleep_cycles) + 1);
                end
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got d=%h eof=%b, required none",
                         tx_data, tx_eof);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e.d || tx_eof !== e.eof ||
                    tx_dest_port !== e.port || tx_dest_ip !== e.ip) begin
                    n_fail++;
                    $display("FAIL beat: got d=%h eof=%b port=%h ip=%h, required d=%h eof=%b port=%h ip=%h",
                             tx_data, tx_eof, tx_dest_port, tx_dest_ip,
                             e.d, e.eof, e.port, e.ip);
                end
            end
            if (tx_eof) begin
                in_pkt    = 1'b0;
                have_prev = 1'b1;
                idle      = 0;
            end else begin
                in_pkt = 1'b1;
            end
        end else begin
            if (in_pkt) begin
                n_tests++;
                n_fail++;
                $display("FAIL bubble: got tx_valid=0 mid-packet, required 1");
                in_pkt = 1'b0;
            end
            idle++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic int msize(input int c);
        return mtail[c] - mhead[c];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            mhead[c] = 0;
            mtail[c] = 0;
            mseq[c]  = '0;
        end
        mlast  = 0;
        mcount = 0;
        movf   = '0;
    endtask

    task automatic wr(input int c, input int n);
        logic [DIN-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            din = '0;
            din[c*DIN +: DIN] = w;
            din_valid = '0;
            din_valid[c] = 1'b1;
            if (msize(c) < DEPTH) begin
                mmem[c][mtail[c] % 1024] = w;
                mtail[c]++;
            end else begin
                movf[c] = 1'b1;
            end
            tick();
        end
        din_valid = '0;
    endtask

    // Drains every packet the model says the DUT will send now,
    // given no further writes and the current configuration.
    task automatic model_release();
        int    c;
        bit    found;
        int    len;
        beat_t b;
        logic [DIN-1:0] w;
        len = int'(pkt_len);
        while (1) begin
            found = 1'b0;
            c = 0;
            for (int i = 1; i <= NCH; i++) begin
                int cc;
                cc = (mlast + i) % NCH;
                if (!found && len >= 1 && len <= DEPTH &&
                    msize(cc) >= len) begin
                    found = 1'b1;
                    c = cc;
                end
            end
            if (!found) break;
            b.port = config_tx_dest_port + 16'(c);
            b.ip   = config_tx_dest_ip;
            if (header_en) begin
                b.d   = {32'h0, 8'(c), mseq[c]};
                b.eof = 1'b0;
                exp_q.push_back(b);
            end
            for (int k = 0; k < len; k++) begin
                w = mmem[c][mhead[c] % 1024];
                mhead[c]++;
                for (int s = 0; s < R; s++) begin
                    b.d   = w[DIN-1-s*DOUT -: DOUT];
                    b.eof = (k == len - 1) && (s == R - 1);
                    exp_q.push_back(b);
                end
            end
            mseq[c] = mseq[c] + 24'd1;
            mcount++;
            mlast = c;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0",
                     exp_q.size());
            exp_q.delete();
        end
        repeat (20) tick();
        chk("pkt_count", 64'(pkt_count), 64'(mcount));
    endtask

    task automatic quiet(input string nm, input int cyc);
        int b0;
        b0 = beats_seen;
        repeat (cyc) tick();
        chk(nm, 64'(beats_seen - b0), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int k;
        int n;
        rst = 1'b1;
        din = '0;
        din_valid = '0;
        pkt_len = 16'd4;
        sleep_cycles = 32'd10;
        header_en = 1'b0;
        config_tx_dest_ip = 32'hC0A8_0A01;
        config_tx_dest_port = 16'd5000;
        tx_afull = 1'b1;
        model_clear();
        repeat (3) tick();
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_eof", 64'(tx_eof), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_fifo_full", 64'(fifo_full), 64'd0);
        rst = 1'b0;
        tick();

        // single packet, no header
        wr(2, 4);
        repeat (20) tick();
        model_release();
        tx_afull = 1'b0;
        drain(300);

        // two channels, headers, round robin
        tx_afull = 1'b1;
        header_en = 1'b1;
        tick();
        wr(0, 8);
        wr(3, 8);
        repeat (20) tick();
        model_release();
        tx_afull = 1'b0;
        drain(400);

        // partial packet stays put until the last word arrives
        repeat (30) tick();
        wr(1, 3);
        quiet("partial_quiet", 40);
        b0 = beats_seen;
        wr(1, 1);
        model_release();
        k = 0;
        while (beats_seen == b0 && k < int'(sleep_cycles) + 2) begin
            tick();
            k++;
        end
        chk("start_latency", 64'(beats_seen > b0), 64'd1);
        drain(300);

        // tx_afull holds off start but not a running packet
        tx_afull = 1'b1;
        wr(0, 4);
        quiet("afull_quiet", 40);
        model_release();
        tx_afull = 1'b0;
        repeat (4) tick();
        tx_afull = 1'b1;
        drain(300);

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            tx_afull = 1'b1;
            pkt_len = 16'($urandom_range(1, 5));
            header_en = 1'($urandom_range(0, 1));
            sleep_cycles = 32'($urandom_range(0, 8));
            config_tx_dest_port = 16'($urandom);
            config_tx_dest_ip = $urandom;
            tick();
            for (int c = 0; c < NCH; c++) begin
                wr(c, $urandom_range(0, 2 * int'(pkt_len) + 1));
            end
            repeat (20) tick();
            model_release();
            tx_afull = 1'b0;
            drain(1000);
        end

        // overflow with pkt_len=0, then a full-depth packet
        sleep_cycles = 32'd10;
        pkt_len = 16'd0;
        tx_afull = 1'b0;
        tick();
        n = DEPTH - msize(1) + 1;
        wr(1, n);
        tick();
        chk("ovf_fifo_full1", 64'(fifo_full[1]), 64'd1);
        chk("ovf_overflow", 64'(overflow), 64'(movf));
        quiet("len0_quiet", 40);
        pkt_len = 16'(DEPTH);
        model_release();
        drain(3000);
        chk("ovf_fifo_full1_after", 64'(fifo_full[1]), 64'd0);

        // reset in the middle of a packet
        tx_afull = 1'b1;
        header_en = 1'b1;
        pkt_len = 16'd8;
        sleep_cycles = 32'd4;
        tick();
        wr(3, 10);
        wr(2, 3);
        repeat (10) tick();
        model_release();
        b0 = beats_seen;
        tx_afull = 1'b0;
        k = 0;
        while (beats_seen < b0 + 5 && k < 100) begin
            tick();
            k++;
        end
        chk("pre_rst_beats", 64'(beats_seen >= b0 + 5), 64'd1);
        mon_off = 1'b1;
        rst = 1'b1;
        tick();
        chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
        chk("midrst_tx_eof", 64'(tx_eof), 64'd0);
        chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
        chk("midrst_fifo_full", 64'(fifo_full), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        mon_off = 1'b0;
        tick();
        pkt_len = 16'd1;
        quiet("flushed_quiet", 40);
        wr(0, 1);
        model_release();
        drain(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
